// File: rtl/alu_if.sv
// Operand/opcode/result bundle for the 4-bit registered ALU.
// The master drives the operands and opcode; the slave returns the registered result and flags.
interface alu_if;
    logic [3:0] a;
    logic [7:4] b;
    logic [9:8] s;
    logic       cin;
    logic [3:0] f;
    logic       cout;
    logic       z;

    modport master (output a, b, s, cin, input f, cout, z);
    modport slave  (input a, b, s, cin, output f, cout, z);
endinterface

// File: rtl/alu.sv
// 4-bit registered ALU: ADD, SUB, SHIFT and AND under a 2-bit opcode.
// The result, carry/borrow and zero flags are registered together with one cycle of latency.
module alu (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);

    function automatic logic is_zero(input logic [3:0] val);
        is_zero = (val == 4'b0000);
    endfunction

    logic [3:0] b_val_s;
    logic [4:0] sum_s;
    logic [4:0] diff_s;
    logic [3:0] f_d, f_q;
    logic       cout_d, cout_q;
    logic       z_d, z_q;

    assign b_val_s = bus.b[7:4];

    // Next-state result and flags from the current operands and opcode
    always_comb begin
        f_d    = 4'b0000;
        cout_d = 1'b0;
        sum_s  = {1'b0, bus.a} + {1'b0, b_val_s} + {4'b0000, bus.cin};
        // Bit 4 of the 5-bit difference is set exactly when a < b + cin
        diff_s = {1'b0, bus.a} - {1'b0, b_val_s} - {4'b0000, bus.cin};
        case (bus.s)
            2'b00: begin
                f_d    = sum_s[3:0];
                cout_d = sum_s[4];
            end
            2'b01: begin
                f_d    = diff_s[3:0];
                cout_d = diff_s[4];
            end
            2'b10: begin
                f_d    = bus.a << bus.b[5:4];
                cout_d = 1'b0;
            end
            2'b11: begin
                f_d    = bus.a & b_val_s;
                cout_d = 1'b0;
            end
            default: begin
                f_d    = 4'b0000;
                cout_d = 1'b0;
            end
        endcase
        z_d = is_zero(f_d);
    end

    // Output registers with synchronous active-low reset taking priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_q    <= 4'b0000;
            cout_q <= 1'b0;
            z_q    <= 1'b1;
        end else begin
            f_q    <= f_d;
            cout_q <= cout_d;
            z_q    <= z_d;
        end
    end

    assign bus.f    = f_q;
    assign bus.cout = cout_q;
    assign bus.z    = z_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the 4-bit registered ALU.
module tb_alu;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_if bus ();

    alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] ef, input logic ec, input logic ez);
        checks = checks + 1;
        assert (bus.f === ef) else begin
            failures = failures + 1;
            $error("FAIL %s.f observed=%b expected=%b", tag, bus.f, ef);
        end
        checks = checks + 1;
        assert (bus.cout === ec) else begin
            failures = failures + 1;
            $error("FAIL %s.cout observed=%b expected=%b", tag, bus.cout, ec);
        end
        checks = checks + 1;
        assert (bus.z === ez) else begin
            failures = failures + 1;
            $error("FAIL %s.z observed=%b expected=%b", tag, bus.z, ez);
        end
    endtask

    // Apply inputs on the falling edge, register on the rising edge, sample 1 time unit later
    task automatic step(input logic rn, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] s, input logic cin);
        @(negedge clk);
        rst_n   = rn;
        bus.a   = a;
        bus.b   = b;
        bus.s   = s;
        bus.cin = cin;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.a    = 4'h0;
        bus.b    = 4'h0;
        bus.s    = 2'b00;
        bus.cin  = 1'b0;

        step(1'b0, 4'hF, 4'hF, 2'b00, 1'b1); check("rst1", 4'h0, 1'b0, 1'b1);
        step(1'b0, 4'h7, 4'h3, 2'b01, 1'b0); check("rst2", 4'h0, 1'b0, 1'b1);

        step(1'b1, 4'b0101, 4'b1100, 2'b00, 1'b0); check("add", 4'b0001, 1'b1, 1'b0);
        step(1'b1, 4'b1001, 4'b0111, 2'b01, 1'b1); check("sub_cin1", 4'b0001, 1'b0, 1'b0);
        step(1'b1, 4'b1001, 4'b0111, 2'b01, 1'b0); check("sub_cin0", 4'b0010, 1'b0, 1'b0);
        step(1'b1, 4'b0000, 4'b0001, 2'b01, 1'b0); check("sub_borrow", 4'b1111, 1'b1, 1'b0);
        step(1'b1, 4'b0011, 4'b1010, 2'b10, 1'b1); check("shl2", 4'b1100, 1'b0, 1'b0);
        step(1'b1, 4'b0011, 4'b0011, 2'b10, 1'b0); check("shl3", 4'b1000, 1'b0, 1'b0);
        step(1'b1, 4'b1010, 4'b1100, 2'b10, 1'b0); check("shl0", 4'b1010, 1'b0, 1'b0);
        step(1'b1, 4'b1111, 4'b1100, 2'b11, 1'b1); check("and", 4'b1100, 1'b0, 1'b0);
        step(1'b1, 4'b0011, 4'b1100, 2'b11, 1'b0); check("and_zero", 4'b0000, 1'b0, 1'b1);
        step(1'b1, 4'hF, 4'hF, 2'b00, 1'b1); check("add_max", 4'hF, 1'b1, 1'b0);
        step(1'b1, 4'h0, 4'h0, 2'b01, 1'b1); check("sub_0_0_1", 4'hF, 1'b1, 1'b0);
        step(1'b1, 4'h8, 4'h8, 2'b00, 1'b0); check("add_wrap_zero", 4'h0, 1'b1, 1'b1);
        step(1'b1, 4'h6, 4'h6, 2'b01, 1'b0); check("sub_equal", 4'h0, 1'b0, 1'b1);

        // Outputs hold between edges even when inputs change
        step(1'b1, 4'h1, 4'h2, 2'b00, 1'b0); check("b2b_add", 4'h3, 1'b0, 1'b0);
        #2;
        bus.a = 4'hE;
        bus.s = 2'b11;
        #1;
        check("hold", 4'h3, 1'b0, 1'b0);

        step(1'b1, 4'h4, 4'h1, 2'b01, 1'b1); check("b2b_sub", 4'h2, 1'b0, 1'b0);
        step(1'b0, 4'h9, 4'h9, 2'b00, 1'b0); check("b2b_rst", 4'h0, 1'b0, 1'b1);
        step(1'b1, 4'hA, 4'h6, 2'b11, 1'b0); check("b2b_and", 4'h2, 1'b0, 1'b0);
        step(1'b1, 4'h5, 4'h5, 2'b10, 1'b1); check("b2b_shl1", 4'hA, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

4-bit registered arithmetic/logic unit with one clock and a synchronous active-low reset. It combines operand `a` and operand `b` under a 2-bit opcode `s`, and registers the 4-bit result `f` plus carry and zero flags. It is a leaf datapath block; the surrounding logic drives the operands and opcode and samples the result one cycle later.

## Interface
Parameters:
- None. All widths are fixed.

Ports (clock and reset first):
- `clk`  input  1  Single clock. All state updates on the rising edge.
- `rst_n`  input  1  Reset, synchronous and active-low. Sampled on the rising edge of `clk`.
- `a`  input  4 `[3:0]`  Operand A, unsigned.
- `b`  input  4 `[7:4]`  Operand B, unsigned.
  - Declared with range `[7:4]`; `b[4]` is the LSB.
  - Treated in arithmetic as the 4-bit value `{b[7],b[6],b[5],b[4]}`.
- `s`  input  2 `[9:8]`  Opcode, declared with range `[9:8]`.
- `cin`  input  1  Carry-in for ADD, borrow-in for SUB. Ignored for SHIFT and AND.
- `f`  output  4 `[3:0]`  Registered result.
- `cout`  output  1  Registered carry-out (ADD) or borrow-out (SUB). 0 for other ops.
- `z`  output  1  Registered zero flag. 1 when the registered `f` equals 4'b0000.

## Operation
- Opcode decode on `s`:
  - `2'b00` ADD: `{cout,f} = a + b + cin`, computed 5 bits wide.
  - `2'b01` SUB: `{borrow,f} = a - b - cin`, computed 5 bits wide, modulo 16.
    - `cout` = 1 iff `a < b + cin` (unsigned borrow).
  - `2'b10` SHIFT: `f = a << b[5:4]`. Logical left shift, zero-filled, truncated to 4 bits. `b[7:6]` is ignored. `cout` = 0.
  - `2'b11` AND: `f = a & b`, bitwise with `a[i]` paired to `b[i+4]`. `cout` = 0.
- `z` is derived from the next-state value of `f`. It is registered together with `f`, never one cycle late.
- All inputs are sampled only at the rising edge of `clk`. There is no enable; a new result is registered every cycle.
- Arithmetic is unsigned. No overflow flag. Results wrap modulo 16.
- The datapath between the input sample and the register is purely combinational. No latches; every opcode path assigns `f` and `cout`.

## Timing
- Latency is one cycle. Inputs present at rising edge N appear on `f`/`cout`/`z` after edge N and hold until edge N+1.
- Reset: when `rst_n` = 0 at a rising edge, then `f` = 4'b0000, `cout` = 0, `z` = 1 after that edge. Inputs are ignored that cycle.
- Reset has priority over any operation.
- Deassertion: the first edge with `rst_n` = 1 registers the result of the inputs present at that edge.
- Reset asserted mid-stream discards the in-flight operation. No partial result is visible.
- Between edges, outputs do not change in response to input changes.
- Boundary cases:
  - ADD `a=4'hF, b=4'hF, cin=1` gives `f=4'hF`, `cout=1`.
  - SUB `a=0, b=0, cin=1` gives `f=4'hF`, `cout=1`.
  - SHIFT by 0 passes `a` through unchanged.
  - SHIFT by 3 keeps only `a[0]` in `f[3]`.

## Test plan
- Reset: hold `rst_n`=0 for 2 edges with arbitrary inputs, then `f`=0000, `cout`=0, `z`=1. Release `rst_n`; the next edge registers a valid result.
- ADD: `a`=0101, `b`=1100, `cin`=0, `s`=00, then after one edge `f`=0001, `cout`=1, `z`=0.
- SUB: `a`=1001, `b`=0111, `cin`=1, `s`=01, then `f`=0001, `cout`=0. Same with `cin`=0 gives `f`=0010. `a`=0000, `b`=0001, `cin`=0 gives `f`=1111, `cout`=1.
- SHIFT: `a`=0011, `b`=1010, `s`=10, giving shift amount 2, then `f`=1100, `cout`=0. Same `a` with `b`=0011 (shift 3) gives `f`=1000.
- AND: `a`=1111, `b`=1100, `s`=11, then `f`=1100, `z`=0. `a`=0011, `b`=1100 gives `f`=0000, `z`=1.
- Back-to-back ops every cycle plus `rst_n` pulsed low mid-sequence: outputs track inputs with exactly one-cycle latency. The reset cycle forces 0000/0/1, and the sequence resumes correctly afterwards.
